// File: rtl/alu_pkg.sv
// Opcode map, class decode helpers and FSM encoding shared by the sequential ALU.
package alu_pkg;

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD  = 4'b0000;
    localparam logic [OP_W-1:0] OP_SUB  = 4'b0001;
    localparam logic [OP_W-1:0] OP_MUL  = 4'b0010;
    localparam logic [OP_W-1:0] OP_DIV  = 4'b0011;
    localparam logic [OP_W-1:0] OP_AND  = 4'b0100;
    localparam logic [OP_W-1:0] OP_OR   = 4'b0101;
    localparam logic [OP_W-1:0] OP_NAND = 4'b0110;
    localparam logic [OP_W-1:0] OP_NOR  = 4'b0111;
    localparam logic [OP_W-1:0] OP_XOR  = 4'b1000;
    localparam logic [OP_W-1:0] OP_XNOR = 4'b1001;
    localparam logic [OP_W-1:0] OP_EQ   = 4'b1010;
    localparam logic [OP_W-1:0] OP_GT   = 4'b1011;
    localparam logic [OP_W-1:0] OP_LT   = 4'b1100;
    localparam logic [OP_W-1:0] OP_SHR  = 4'b1101;
    localparam logic [OP_W-1:0] OP_SHL  = 4'b1110;
    localparam logic [OP_W-1:0] OP_NOP  = 4'b1111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DIV  = 1'b1
    } state_e;

    function automatic logic is_arith(input logic [OP_W-1:0] op);
        return (op <= OP_DIV);
    endfunction

    function automatic logic is_logic(input logic [OP_W-1:0] op);
        return (op >= OP_AND) && (op <= OP_XNOR);
    endfunction

    function automatic logic is_cmp(input logic [OP_W-1:0] op);
        return (op >= OP_EQ) && (op <= OP_LT);
    endfunction

    function automatic logic is_shift(input logic [OP_W-1:0] op);
        return (op == OP_SHR) || (op == OP_SHL);
    endfunction

endpackage

// File: rtl/alu_divider.sv
// Restoring unsigned divider, one quotient bit per clock, MSB first.
// The final quotient/remainder are offered combinationally on the last
// iteration so the caller can register them on that same edge.
module alu_divider #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o_c,
    output logic [WIDTH-1:0] quot_o_c,
    output logic [WIDTH-1:0] rem_o_c
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic             busy_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quot_q;

    logic [WIDTH:0]   rem_sh;
    logic             ge;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quot_d;

    // One restoring step: shift in next dividend bit, subtract if it fits.
    always_comb begin
        rem_sh = {rem_q, dvd_q[WIDTH-1]};
        ge     = (rem_sh >= {1'b0, dvs_q});
        rem_d  = ge ? WIDTH'(rem_sh - {1'b0, dvs_q}) : rem_sh[WIDTH-1:0];
        quot_d = {quot_q[WIDTH-2:0], ge};
    end

    assign busy_o   = busy_q;
    assign done_o_c = busy_q && (cnt_q == '0);
    assign quot_o_c = quot_d;
    assign rem_o_c  = rem_d;

    // Operand latch on start, then iterate until the counter runs out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            dvd_q  <= '0;
            dvs_q  <= '0;
            rem_q  <= '0;
            quot_q <= '0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= CNT_W'(WIDTH - 1);
            dvd_q  <= dividend_i;
            dvs_q  <= divisor_i;
            rem_q  <= '0;
            quot_q <= '0;
        end else if (busy_q) begin
            rem_q  <= rem_d;
            quot_q <= quot_d;
            dvd_q  <= {dvd_q[WIDTH-2:0], 1'b0};
            if (cnt_q == '0) begin
                busy_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/alu_seq_param.sv
// Registered WIDTH-bit ALU with valid handshake and multi-cycle divide.
module alu_seq_param #(
    parameter  int unsigned WIDTH     = 16,
    localparam int unsigned OUT_WIDTH = 2 * WIDTH
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [3:0]           ALU_FUN,
    input  logic                 ALU_EN,
    output logic [OUT_WIDTH-1:0] ALU_OUT,
    output logic                 OUT_VALID,
    output logic                 BUSY,
    output logic                 Arith_Flag,
    output logic                 Logic_Flag,
    output logic                 CMP_Flag,
    output logic                 Shift_Flag,
    output logic                 DIV_ERR
);

    import alu_pkg::*;

    state_e                 state_q;
    logic [OUT_WIDTH-1:0]   out_q;
    logic                   valid_q;
    logic                   arith_q;
    logic                   logic_q;
    logic                   cmp_q;
    logic                   shift_q;
    logic                   div_err_q;

    logic [OUT_WIDTH-1:0]   res_c;
    logic [WIDTH:0]         diff_c;
    logic [WIDTH-1:0]       narrow_c;
    logic                   div_start_c;
    logic                   div_busy;
    logic                   div_done_c;
    logic [WIDTH-1:0]       div_quot_c;
    logic [WIDTH-1:0]       div_rem_c;

    assign div_start_c = (state_q == ST_IDLE) && ALU_EN &&
                         (ALU_FUN == OP_DIV) && (B != '0);

    alu_divider #(.WIDTH(WIDTH)) u_div (
        .clk        (CLK),
        .rst_n      (RST),
        .start_i    (div_start_c),
        .dividend_i (A),
        .divisor_i  (B),
        .busy_o     (div_busy),
        .done_o_c   (div_done_c),
        .quot_o_c   (div_quot_c),
        .rem_o_c    (div_rem_c)
    );

    // Single-cycle datapath; the DIV entry is only used for B == 0.
    always_comb begin
        res_c    = '0;
        narrow_c = '0;
        diff_c   = (WIDTH+1)'(A) - (WIDTH+1)'(B);
        case (ALU_FUN)
            OP_ADD:  res_c = OUT_WIDTH'(A) + OUT_WIDTH'(B);
            OP_SUB:  res_c = OUT_WIDTH'(diff_c);
            OP_MUL:  res_c = OUT_WIDTH'(A) * OUT_WIDTH'(B);
            OP_DIV:  res_c = {A, {WIDTH{1'b1}}};
            OP_AND:  begin narrow_c = A & B;    res_c = OUT_WIDTH'(narrow_c); end
            OP_OR:   begin narrow_c = A | B;    res_c = OUT_WIDTH'(narrow_c); end
            OP_NAND: begin narrow_c = ~(A & B); res_c = OUT_WIDTH'(narrow_c); end
            OP_NOR:  begin narrow_c = ~(A | B); res_c = OUT_WIDTH'(narrow_c); end
            OP_XOR:  begin narrow_c = A ^ B;    res_c = OUT_WIDTH'(narrow_c); end
            OP_XNOR: begin narrow_c = ~(A ^ B); res_c = OUT_WIDTH'(narrow_c); end
            OP_EQ:   res_c = (A == B) ? OUT_WIDTH'(1) : '0;
            OP_GT:   res_c = (A > B)  ? OUT_WIDTH'(2) : '0;
            OP_LT:   res_c = (A < B)  ? OUT_WIDTH'(3) : '0;
            OP_SHR:  begin narrow_c = A >> 1;   res_c = OUT_WIDTH'(narrow_c); end
            OP_SHL:  begin narrow_c = A << 1;   res_c = OUT_WIDTH'(narrow_c); end
            default: res_c = '0;
        endcase
    end

    // IDLE/DIV control with result, flag and valid registers.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            out_q     <= '0;
            valid_q   <= 1'b0;
            arith_q   <= 1'b0;
            logic_q   <= 1'b0;
            cmp_q     <= 1'b0;
            shift_q   <= 1'b0;
            div_err_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (div_start_c) begin
                        state_q <= ST_DIV;
                    end else if (ALU_EN) begin
                        out_q     <= res_c;
                        valid_q   <= 1'b1;
                        arith_q   <= is_arith(ALU_FUN);
                        logic_q   <= is_logic(ALU_FUN);
                        cmp_q     <= is_cmp(ALU_FUN);
                        shift_q   <= is_shift(ALU_FUN);
                        div_err_q <= (ALU_FUN == OP_DIV);
                    end
                end
                ST_DIV: begin
                    if (div_done_c) begin
                        state_q   <= ST_IDLE;
                        out_q     <= {div_rem_c, div_quot_c};
                        valid_q   <= 1'b1;
                        arith_q   <= 1'b1;
                        logic_q   <= 1'b0;
                        cmp_q     <= 1'b0;
                        shift_q   <= 1'b0;
                        div_err_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ALU_OUT    = out_q;
    assign OUT_VALID  = valid_q;
    assign BUSY       = div_busy;
    assign Arith_Flag = arith_q;
    assign Logic_Flag = logic_q;
    assign CMP_Flag   = cmp_q;
    assign Shift_Flag = shift_q;
    assign DIV_ERR    = div_err_q;

endmodule

// File: tb/tb_alu_seq_param.sv
// Directed bench for alu_seq_param at WIDTH=16 and WIDTH=8.
module tb_alu_seq_param;

    logic        CLK;
    logic        RST;
    logic [15:0] A, B;
    logic [3:0]  FUN;
    logic        EN;
    logic [31:0] OUT;
    logic        VALID, BUSY_S, AF, LF, CF, SF, DE;

    logic [7:0]  A8, B8;
    logic [3:0]  FUN8;
    logic        EN8;
    logic [15:0] OUT8;
    logic        VALID8, BUSY8, AF8, LF8, CF8, SF8, DE8;

    int n_checks = 0;
    int n_errors = 0;

    alu_seq_param #(.WIDTH(16)) u_dut (
        .CLK(CLK), .RST(RST), .A(A), .B(B), .ALU_FUN(FUN), .ALU_EN(EN),
        .ALU_OUT(OUT), .OUT_VALID(VALID), .BUSY(BUSY_S),
        .Arith_Flag(AF), .Logic_Flag(LF), .CMP_Flag(CF), .Shift_Flag(SF),
        .DIV_ERR(DE)
    );

    alu_seq_param #(.WIDTH(8)) u_dut8 (
        .CLK(CLK), .RST(RST), .A(A8), .B(B8), .ALU_FUN(FUN8), .ALU_EN(EN8),
        .ALU_OUT(OUT8), .OUT_VALID(VALID8), .BUSY(BUSY8),
        .Arith_Flag(AF8), .Logic_Flag(LF8), .CMP_Flag(CF8), .Shift_Flag(SF8),
        .DIV_ERR(DE8)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [4:0] flags();
        return {AF, LF, CF, SF, DE};
    endfunction

    // Single-cycle op: request one cycle, then check the result cycle.
    task automatic op1(input string tag, input logic [3:0] f, input logic [15:0] a,
                       input logic [15:0] b, input logic [31:0] exp, input logic [4:0] exp_fl);
        A = a; B = b; FUN = f; EN = 1'b1;
        tick();
        EN = 1'b0;
        chk({tag, "_valid"}, VALID, 1'b1);
        chk({tag, "_out"}, OUT, exp);
        chk({tag, "_flags"}, flags(), exp_fl);
        tick();
        chk({tag, "_valid_drop"}, VALID, 1'b0);
    endtask

    // Divide: start at edge k, observe cycles k+1..k+24, optionally poke an ADD at cycle inj.
    task automatic op_div(input logic [15:0] a, input logic [15:0] b, input int inj,
                          output int lat, output int busy_cyc, output int valids,
                          output logic [31:0] res);
        A = a; B = b; FUN = 4'b0011; EN = 1'b1;
        tick();
        EN = 1'b0;
        A = 16'hAAAA; B = 16'h0000;
        lat = 0; busy_cyc = 0; valids = 0; res = '0;
        for (int n = 1; n <= 24; n++) begin
            if (BUSY_S) busy_cyc++;
            if (VALID) begin
                valids++;
                if (lat == 0) begin
                    lat = n;
                    res = OUT;
                end
            end
            if (n == inj) begin
                A = 16'd1; B = 16'd1; FUN = 4'b0000; EN = 1'b1;
            end else begin
                EN = 1'b0;
            end
            tick();
        end
    endtask

    logic [3:0]  v_op [7] = '{4'b0000, 4'b0001, 4'b0010, 4'b1011, 4'b1100, 4'b1101, 4'b1110};
    logic [31:0] v_ex [7] = '{32'd18, 32'd12, 32'd45, 32'd2, 32'd0, 32'd7, 32'd30};
    logic [4:0]  v_fl [7] = '{5'b10000, 5'b10000, 5'b10000, 5'b00100, 5'b00100, 5'b00010, 5'b00010};

    initial begin
        int lat, bc, nv;
        logic [31:0] res;

        A = '0; B = '0; FUN = '0; EN = 1'b0;
        A8 = '0; B8 = '0; FUN8 = '0; EN8 = 1'b0;
        RST = 1'b0;
        tick();
        tick();
        chk("rst_out", OUT, 32'd0);
        chk("rst_valid", VALID, 1'b0);
        chk("rst_busy", BUSY_S, 1'b0);
        chk("rst_flags", flags(), 5'b00000);
        RST = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            op1($sformatf("op%0d", i), v_op[i], 16'd15, 16'd3, v_ex[i], v_fl[i]);
        end

        op1("mul_ffff", 4'b0010, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 5'b10000);
        op1("add_ffff", 4'b0000, 16'hFFFF, 16'hFFFF, 32'h0001FFFE, 5'b10000);
        op1("sub_borrow", 4'b0001, 16'h0000, 16'h0001, 32'h0001FFFF, 5'b10000);
        op1("nand", 4'b0110, 16'd15, 16'd3, 32'h0000FFFC, 5'b01000);
        op1("xnor", 4'b1001, 16'h00F0, 16'h0FF0, 32'h0000F0FF, 5'b01000);
        op1("eq", 4'b1010, 16'd5, 16'd5, 32'd1, 5'b00100);
        op1("nop", 4'b1111, 16'd5, 16'd5, 32'd0, 5'b00000);

        op_div(16'd15, 16'd3, 0, lat, bc, nv, res);
        chk("div15_lat", 64'(lat), 64'd17);
        chk("div15_busy", 64'(bc), 64'd16);
        chk("div15_nvalid", 64'(nv), 64'd1);
        chk("div15_out", res, 32'h00000005);
        chk("div15_flags", flags(), 5'b10000);

        op_div(16'd17, 16'd5, 0, lat, bc, nv, res);
        chk("div17_lat", 64'(lat), 64'd17);
        chk("div17_out", res, 32'h00020003);

        op1("div0", 4'b0011, 16'd9, 16'd0, 32'h0009FFFF, 5'b10001);
        chk("div0_busy", BUSY_S, 1'b0);
        op1("and_clr", 4'b0100, 16'd9, 16'd0, 32'd0, 5'b01000);

        op_div(16'd15, 16'd3, 5, lat, bc, nv, res);
        chk("inj_nvalid", 64'(nv), 64'd1);
        chk("inj_lat", 64'(lat), 64'd17);
        chk("inj_out", res, 32'h00000005);

        op1("pre_rst", 4'b0000, 16'd1, 16'd2, 32'd3, 5'b10000);
        A = 16'd15; B = 16'd3; FUN = 4'b0011; EN = 1'b1;
        tick();
        EN = 1'b0;
        for (int n = 1; n < 8; n++) tick();
        chk("mid_busy", BUSY_S, 1'b1);
        RST = 1'b0;
        tick();
        RST = 1'b1;
        chk("mrst_out", OUT, 32'd0);
        chk("mrst_busy", BUSY_S, 1'b0);
        chk("mrst_flags", flags(), 5'b00000);
        chk("mrst_valid", VALID, 1'b0);
        nv = 0;
        for (int n = 0; n < 24; n++) begin
            if (VALID || BUSY_S) nv++;
            tick();
        end
        chk("mrst_quiet", 64'(nv), 64'd0);
        op1("post_rst_add", 4'b0000, 16'd15, 16'd3, 32'd18, 5'b10000);

        A8 = 8'd200; B8 = 8'd7; FUN8 = 4'b0011; EN8 = 1'b1;
        tick();
        EN8 = 1'b0;
        lat = 0; res = '0;
        for (int n = 1; n <= 20; n++) begin
            if (VALID8 && lat == 0) begin
                lat = n;
                res = 32'(OUT8);
            end
            tick();
        end
        chk("w8_lat", 64'(lat), 64'd9);
        chk("w8_out", res, 32'h0000041C);
        chk("w8_arith", AF8, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_seq_param.md
Name: alu_seq_param

Overview:
Parameterised, registered successor to the 16-bit ALU: WIDTH-bit operands, the same 16-function opcode map, and a 2*WIDTH-bit result that keeps the full product and quotient/remainder.
- Adds an enable/valid handshake, a BUSY output, and a multi-cycle restoring divider with divide-by-zero detection.
- Sits between the register file and the system controller. The controller issues one operation at a time and samples the result on OUT_VALID.

Parameters:
WIDTH, 16, operand width in bits (legal range 4 to 32)
OUT_WIDTH, 2*WIDTH, result width (derived; do not override)

Ports:
CLK  in  1  system clock; all logic on the rising edge
RST  in  1  synchronous, active-low reset
A  in  WIDTH  operand A, sampled when ALU_EN=1 and BUSY=0
B  in  WIDTH  operand B, sampled with A
ALU_FUN  in  4  opcode, sampled with A
ALU_EN  in  1  operation request, single-cycle pulse or level
ALU_OUT  out  OUT_WIDTH  registered result, held until the next result
OUT_VALID  out  1  one-cycle pulse: ALU_OUT is new
BUSY  out  1  divide in progress; ALU_EN is ignored while high
Arith_Flag  out  1  last op was 0000-0011
Logic_Flag  out  1  last op was 0100-1001
CMP_Flag  out  1  last op was 1010-1100
Shift_Flag  out  1  last op was 1101-1110
DIV_ERR  out  1  last op was a divide with B=0

Behaviour:
- Reset: when RST=0 at a rising CLK edge, every output goes to 0, the FSM returns to IDLE and the divide counter clears. This applies in any state, including mid-divide; the partial result is discarded.
- Opcode map. All results are zero-extended to OUT_WIDTH unless stated.
  - 0000 A+B; carry lands in bit WIDTH.
  - 0001 A-B, computed in WIDTH+1 bits; bit WIDTH is the borrow.
  - 0010 A*B, full OUT_WIDTH product.
  - 0011 A/B, multi-cycle; quotient in [WIDTH-1:0], remainder in [OUT_WIDTH-1:WIDTH].
  - 0100 AND; 0101 OR; 0110 NAND; 0111 NOR; 1000 XOR; 1001 XNOR. Results are WIDTH bits, upper half 0.
  - 1010 gives 1 if A==B, else 0.
  - 1011 gives 2 if A>B, else 0.
  - 1100 gives 3 if A<B, else 0. All compares are unsigned.
  - 1101 A>>1; 1110 A<<1, truncated to WIDTH bits.
  - 1111 gives 0, and all four class flags are 0.
- Flags are registered together with ALU_OUT and held until the next result. Exactly one class flag is high, except for opcode 1111.
- FSM has two states, IDLE and DIV.
- IDLE, ALU_EN=1, opcode not 0011: at edge k the result and flags are registered, OUT_VALID=1 for cycle k+1 only, and the FSM stays in IDLE. Latency is 1 cycle; back-to-back requests give 1 result per cycle.
- IDLE, ALU_EN=1, opcode 0011, B=0: handled in a single cycle like the other ops.
  - Quotient = all ones; remainder = A.
  - DIV_ERR=1, Arith_Flag=1.
- IDLE, ALU_EN=1, opcode 0011, B≠0: at edge k, latch A and B, clear the remainder register, counter=WIDTH-1, BUSY=1, go to DIV. OUT_VALID stays 0 and ALU_OUT holds its old value.
- DIV: one restoring iteration per edge, MSB first: shift the remainder left with the next dividend bit, subtract B if the remainder ≥ B, and shift the quotient bit in.
  - On the edge where the counter is 0, write the final quotient and remainder to ALU_OUT, set Arith_Flag=1 and DIV_ERR=0, pulse OUT_VALID, drop BUSY, and return to IDLE.
  - Total: request at edge k gives OUT_VALID in cycle k+WIDTH+1.
- ALU_EN while BUSY=1 is ignored entirely; the request is not queued.
- A/B/ALU_FUN changes during DIV have no effect, because operands were latched at edge k.
- OUT_VALID=0 in every cycle with no new result. DIV_ERR is cleared by any non-erroring new result.

Decomposition:
- Package alu_pkg holds:
  - 4-bit opcode localparams (OP_ADD … OP_NOP = 4'b1111)
  - class decode functions: is_arith, is_logic, is_cmp, is_shift
  - FSM state encoding (ST_IDLE, ST_DIV)
- One sub-module, alu_divider: WIDTH-parameterised restoring divider with a start/busy/done interface and quotient/remainder outputs.
- The top level holds the combinational single-cycle datapath, the result/flag registers and the handshake.

Test Plan:
- WIDTH=16, A=15, B=3, opcodes 0000, 0001, 0010, 1011, 1100, 1101, 1110 each with a one-cycle ALU_EN. Expect ALU_OUT = 18, 12, 45, 2, 0, 7, 30. OUT_VALID pulses the cycle after each request, with the correct single class flag.
- A=0xFFFF, B=0xFFFF: MUL gives 0xFFFE0001 and ADD gives 0x0001FFFE. Then A=0, B=1: SUB gives 0x0001FFFF (borrow bit set).
- A=15, B=3, DIV. BUSY is high for 16 cycles; OUT_VALID comes 17 cycles after the request with ALU_OUT=0x00000005. Then A=17, B=5 gives 0x00020003.
- A=9, B=0, DIV: result the next cycle, ALU_OUT=0x0009FFFF, DIV_ERR=1, BUSY never asserted. A following AND clears DIV_ERR.
- During DIV (A=15, B=3), pulse ALU_EN with ADD at cycle 5. The ADD is ignored, only the DIV result appears, and OUT_VALID pulses exactly once.
- Drive RST=0 for one cycle at cycle 8 of a divide. All outputs read 0 on the next cycle, BUSY=0, and no OUT_VALID follows. A fresh ADD after reset completes normally. Repeat with WIDTH=8: 200/7 gives 0x041C.
